// File: rtl/gpio_in_cond_pkg.sv
//------------------------------------------------------------------------------
// Module : gpio_in_cond_pkg
// Brief  : Constants and types shared by the GPIO input conditioner.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpio_in_cond_pkg;

   localparam int GPIO_WIDTH              = 32;
   localparam int GPIO_DEB_CYCLES_DEFAULT = 4;
   localparam int GPIO_IRQ_BIT            = 5;

   typedef struct packed {
      logic rise;
      logic fall;
   } gpio_edge_t;

   function automatic int deb_cnt_w(input int deb_cycles);
      return $clog2(deb_cycles + 1);
   endfunction

endpackage : gpio_in_cond_pkg

`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
//------------------------------------------------------------------------------
// Module : gpio_debounce_bit
// Brief  : Two-flop synchroniser, persistence counter and edge pulses for one pin.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpio_debounce_bit
   import gpio_in_cond_pkg::*;
#(
   parameter int DEB_CYCLES = GPIO_DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int              CNT_W      = deb_cnt_w(DEB_CYCLES);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differs;
   logic             w_accept;

   assign w_differs = (r_sync2 != r_stable);
   assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         // Any return to the stable level restarts the persistence count.
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Pulses describe the level change taking effect on the coming edge.
   assign o_level = r_stable;
   assign o_rise  = w_accept &  r_sync2;
   assign o_fall  = w_accept & ~r_sync2;

endmodule : gpio_debounce_bit

`default_nettype wire

// File: rtl/gpio_in_cond.sv
//------------------------------------------------------------------------------
// Module : gpio_in_cond
// Brief  : Per-pin debounce, sticky W1C edge flags and masked registered irq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpio_in_cond
   import gpio_in_cond_pkg::*;
#(
   parameter int WIDTH      = GPIO_WIDTH,
   parameter int DEB_CYCLES = GPIO_DEB_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins_in,
   input  logic             clr_we,
   input  logic [WIDTH-1:0] clr_data,
   input  logic [WIDTH-1:0] irq_mask,
   output logic [WIDTH-1:0] gp_in,
   output logic [WIDTH-1:0] rise_flags,
   output logic [WIDTH-1:0] fall_flags,
   output logic             irq
);

   gpio_edge_t       w_edge [WIDTH];
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic             r_irq;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      gpio_debounce_bit #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .i_pin   (pins_in[g]),
         .o_level (gp_in[g]),
         .o_rise  (w_edge[g].rise),
         .o_fall  (w_edge[g].fall)
      );
      assign w_rise[g] = w_edge[g].rise;
      assign w_fall[g] = w_edge[g].fall;
   end

   assign w_clr = clr_we ? clr_data : '0;

   // A new edge ORs in after the clear, so it wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise <= '0;
         r_fall <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_rise <= (r_rise & ~w_clr) | w_rise;
         r_fall <= (r_fall & ~w_clr) | w_fall;
         r_irq  <= |((r_rise | r_fall) & irq_mask);
      end
   end

   assign rise_flags = r_rise;
   assign fall_flags = r_fall;
   assign irq        = r_irq;

endmodule : gpio_in_cond

`default_nettype wire
